// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyph patterns (gfedcba, 0 = segment ON),
// the decimal-point OFF level and an index-width helper.
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic DP_OFF = 1'b1;

   // Bits needed to hold 0..value-1, never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Nibble to common-anode glyph decoder. Values 10-15 render as letters only when
// hex_mode is set; otherwise they are dark.
module seven_seg_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] glyph
);

   // Table lookup of the segment pattern for the selected nibble.
   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = SEG_0;
         4'h1: glyph = SEG_1;
         4'h2: glyph = SEG_2;
         4'h3: glyph = SEG_3;
         4'h4: glyph = SEG_4;
         4'h5: glyph = SEG_5;
         4'h6: glyph = SEG_6;
         4'h7: glyph = SEG_7;
         4'h8: glyph = SEG_8;
         4'h9: glyph = SEG_9;
         4'hA: glyph = hex_mode ? SEG_A : SEG_BLANK;
         4'hB: glyph = hex_mode ? SEG_B : SEG_BLANK;
         4'hC: glyph = hex_mode ? SEG_C : SEG_BLANK;
         4'hD: glyph = hex_mode ? SEG_D : SEG_BLANK;
         4'hE: glyph = hex_mode ? SEG_E : SEG_BLANK;
         4'hF: glyph = hex_mode ? SEG_F : SEG_BLANK;
         default: glyph = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. A shadow frame is captured on load and
// handed to the display frame only when the scan wraps to digit 0, so a frame never tears.
// Each digit slot starts with a guard window where every anode is off to stop ghosting.
// Optional per-digit blinking is compiled in when SEG_BLINK_EN is defined.
//
// All outputs are registered and computed from the next-state counter/index/frame, so the
// value seen on the pins in a cycle always corresponds to the counter value of that cycle.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 16,
   parameter int HEX_MODE     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic [7:0]              blink_div,
`endif
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam int CNT_W = clog2(SLOT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic             HEX_EN   = (HEX_MODE != 0);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [NUM_DIGITS-1:0][3:0] sh_dig_q, sh_dig_d, dsp_dig_q, dsp_dig_d;
   logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
   logic [NUM_DIGITS-1:0]      sh_blank_q, sh_blank_d, dsp_blank_q, dsp_blank_d;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_tick_q, frame_tick_d;

   logic       slot_end;
   logic       wrap;
   logic [3:0] sel_nib;
   logic       sel_dp;
   logic       sel_dark;
   logic [6:0] glyph;

`ifdef SEG_BLINK_EN
   logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, dsp_blink_q, dsp_blink_d;
   logic [7:0]            bdiv_cnt_q, bdiv_cnt_d;
   logic                  phase_q, phase_d;
`endif

   // Slot counter and digit index; wrap marks the last cycle of the last digit slot.
   always_comb begin
      slot_end = (cnt_q == CNT_LAST);
      wrap     = slot_end && (idx_q == IDX_LAST);
      cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      frame_tick_d = wrap;
   end

   // Shadow frame follows load; display frame takes the pre-edge shadow only on wrap.
   always_comb begin
      sh_dig_d    = load ? digits_in : sh_dig_q;
      sh_dp_d     = load ? dp_in     : sh_dp_q;
      sh_blank_d  = load ? blank_in  : sh_blank_q;
      dsp_dig_d   = wrap ? sh_dig_q   : dsp_dig_q;
      dsp_dp_d    = wrap ? sh_dp_q    : dsp_dp_q;
      dsp_blank_d = wrap ? sh_blank_q : dsp_blank_q;
   end

`ifdef SEG_BLINK_EN
   // Blink phase flips once every blink_div+1 frames, evaluated only at wrap.
   always_comb begin
      sh_blink_d  = load ? blink_in : sh_blink_q;
      dsp_blink_d = wrap ? sh_blink_q : dsp_blink_q;
      bdiv_cnt_d  = bdiv_cnt_q;
      phase_d     = phase_q;
      if (wrap) begin
         if (bdiv_cnt_q >= blink_div) begin
            bdiv_cnt_d = '0;
            phase_d    = ~phase_q;
         end else begin
            bdiv_cnt_d = bdiv_cnt_q + 8'd1;
         end
      end
   end
`endif

   // Select the digit being shown next cycle and decide whether it is dark.
   always_comb begin
      sel_nib  = dsp_dig_d[idx_d];
      sel_dp   = dsp_dp_d[idx_d];
      sel_dark = dsp_blank_d[idx_d];
`ifdef SEG_BLINK_EN
      sel_dark = sel_dark | (dsp_blink_d[idx_d] & phase_d);
`endif
   end

   seven_seg_glyph u_glyph (
      .nibble   (sel_nib),
      .hex_mode (HEX_EN),
      .glyph    (glyph)
   );

   // Pin values: everything off in the guard window, else one anode low with its glyph.
   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = DP_OFF;
      if (cnt_d >= GUARD_C) begin
         an_d = ~(NUM_DIGITS'(1) << idx_d);
         if (!sel_dark) begin
            seg_d = glyph;
            dp_d  = ~sel_dp;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_dig_q     <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         dsp_dig_q    <= '0;
         dsp_dp_q     <= '0;
         dsp_blank_q  <= '1;
         seg_q        <= SEG_BLANK;
         dp_q         <= DP_OFF;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sh_dig_q     <= sh_dig_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         dsp_dig_q    <= dsp_dig_d;
         dsp_dp_q     <= dsp_dp_d;
         dsp_blank_q  <= dsp_blank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

`ifdef SEG_BLINK_EN
   // Blink state registers; phase starts visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_blink_q  <= '0;
         dsp_blink_q <= '0;
         bdiv_cnt_q  <= '0;
         phase_q     <= 1'b0;
      end else begin
         sh_blink_q  <= sh_blink_d;
         dsp_blink_q <= dsp_blink_d;
         bdiv_cnt_q  <= bdiv_cnt_d;
         phase_q     <= phase_d;
      end
   end
`endif

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (decimal and hex glyph modes) share the
// same stimulus and are compared every cycle against a timeline model driven by the cycle
// count since reset. SEG_BLINK_EN adds the blink ports and blink model.
module tb_seven_seg_scan_driver;

   localparam int N = 4;
   localparam int S = 20;
   localparam int G = 2;
   localparam int P = N * S;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [4*N-1:0] digits_in = '0;
   logic [N-1:0]  dp_in = '0;
   logic [N-1:0]  blank_in = '0;
`ifdef SEG_BLINK_EN
   logic [N-1:0]  blink_in = '0;
   logic [7:0]    blink_div = 8'd1;
`endif

   logic [6:0]   seg0, seg1;
   logic         dp0, dp1, ft0, ft1;
   logic [N-1:0] an0, an1;

   seven_seg_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G), .HEX_MODE(0)) dut_dec (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
`ifdef SEG_BLINK_EN
      .blink_in(blink_in), .blink_div(blink_div),
`endif
      .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
   );

   seven_seg_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G), .HEX_MODE(1)) dut_hex (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
`ifdef SEG_BLINK_EN
      .blink_in(blink_in), .blink_div(blink_div),
`endif
      .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: time since reset plus the two frames as plain variables.
   int           t;
   logic [15:0]  m_sh_dig, m_ds_dig;
   logic [N-1:0] m_sh_dp, m_ds_dp, m_sh_bl, m_ds_bl;
   logic [N-1:0] m_sh_bk, m_ds_bk;
   logic [6:0]   glyph_tab [16];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%02h expected=%02h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t        = 0;
      m_sh_dig = '0;
      m_ds_dig = '0;
      m_sh_dp  = '0;
      m_ds_dp  = '0;
      m_sh_bl  = '1;
      m_ds_bl  = '1;
      m_sh_bk  = '0;
      m_ds_bk  = '0;
   endtask

   task automatic check_outputs();
      int         cnt, dig, f;
      logic [3:0] nib;
      logic       dark;
      logic [N-1:0] e_an;
      logic [6:0] e_seg0, e_seg1;
      logic       e_dp, e_ft;
      cnt    = t % S;
      dig    = (t / S) % N;
      f      = t / P;
      e_an   = '1;
      e_seg0 = 7'h7F;
      e_seg1 = 7'h7F;
      e_dp   = 1'b1;
      e_ft   = (t > 0) && (t % P == 0);
      if (cnt >= G) begin
         e_an = ~(N'(1) << dig);
         dark = m_ds_bl[dig];
`ifdef SEG_BLINK_EN
         if (m_ds_bk[dig] && ((f / (int'(blink_div) + 1)) % 2 == 1)) dark = 1'b1;
`endif
         if (!dark) begin
            nib    = m_ds_dig[dig*4 +: 4];
            e_seg1 = glyph_tab[nib];
            e_seg0 = (nib > 4'd9) ? 7'h7F : glyph_tab[nib];
            e_dp   = ~m_ds_dp[dig];
         end
      end
      if (f < 0) e_dp = 1'b1;
      chk("an_dec",  8'(an0),  8'(e_an));
      chk("an_hex",  8'(an1),  8'(e_an));
      chk("seg_dec", 8'(seg0), 8'(e_seg0));
      chk("seg_hex", 8'(seg1), 8'(e_seg1));
      chk("dp_dec",  8'(dp0),  8'(e_dp));
      chk("dp_hex",  8'(dp1),  8'(e_dp));
      chk("ft_dec",  8'(ft0),  8'(e_ft));
      chk("ft_hex",  8'(ft1),  8'(e_ft));
   endtask

   // One clock; ld strobes load with the currently driven inputs.
   task automatic step(input bit ld);
      load = ld;
      @(posedge clk);
      t++;
      if (t % P == 0) begin
         m_ds_dig = m_sh_dig;
         m_ds_dp  = m_sh_dp;
         m_ds_bl  = m_sh_bl;
         m_ds_bk  = m_sh_bk;
      end
      if (ld) begin
         m_sh_dig = digits_in;
         m_sh_dp  = dp_in;
         m_sh_bl  = blank_in;
`ifdef SEG_BLINK_EN
         m_sh_bk  = blink_in;
`endif
      end
      #1;
      load = 1'b0;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic set_inputs(input logic [15:0] d, input logic [N-1:0] p, input logic [N-1:0] b);
      digits_in = d;
      dp_in     = p;
      blank_in  = b;
`ifdef SEG_BLINK_EN
      blink_in  = N'($urandom);
`endif
   endtask

   task automatic check_reset_outputs();
      chk("rst_an",  8'(an0),  8'hF);
      chk("rst_seg", 8'(seg1), 8'h7F);
      chk("rst_dp",  8'(dp0),  8'h1);
      chk("rst_ft",  8'(ft1),  8'h0);
   endtask

   initial begin
      glyph_tab[0]  = 7'h40; glyph_tab[1]  = 7'h79; glyph_tab[2]  = 7'h24; glyph_tab[3]  = 7'h30;
      glyph_tab[4]  = 7'h19; glyph_tab[5]  = 7'h12; glyph_tab[6]  = 7'h02; glyph_tab[7]  = 7'h78;
      glyph_tab[8]  = 7'h00; glyph_tab[9]  = 7'h10; glyph_tab[10] = 7'h08; glyph_tab[11] = 7'h03;
      glyph_tab[12] = 7'h46; glyph_tab[13] = 7'h21; glyph_tab[14] = 7'h06; glyph_tab[15] = 7'h0E;
      model_reset();

      // Reset held across edges, then released between edges.
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_outputs();
      #2;
      rst = 1'b0;
      #1;
      check_outputs();

      // No load: everything dark, frame_tick every P cycles.
      run(2 * P + 10);

      // 1234 with decimal point on digit 0.
      set_inputs(16'h1234, 4'b0001, 4'b0000);
      step(1'b1);
      run(2 * P);

      // Hex letters and a blanked digit.
      set_inputs(16'hABCF, 4'b1010, 4'b0010);
      step(1'b1);
      run(P + 7);

      // Load landing exactly on the wrap edge.
      for (int k = 0; k < P && ((t + 1) % P != 0); k++) step(1'b0);
      set_inputs(16'h9A05, 4'b0110, 4'b0000);
      step(1'b1);
      run(2 * P);

      // Randomized frames at random times.
      for (int r = 0; r < 16; r++) begin
         set_inputs(16'($urandom), N'($urandom), N'($urandom & $urandom));
         step(1'b1);
         run($urandom_range(1, 120));
      end

      // Asynchronous reset in the middle of slot 2.
      for (int k = 0; k < P && !(((t / S) % N == 2) && (t % S == 7)); k++) step(1'b0);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      check_reset_outputs();
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      set_inputs(16'h5678, 4'b1000, 4'b0000);
      step(1'b1);
      run(3 * P);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
